alu_step_sequencer: RTL and testbench
=====================================

Name: alu_step_sequencer

Overview:
Controller that sequences the multi-function ALU for board-level demonstration. Turns a debounced step button, or a periodic auto tick, into one ALU operation per trigger. Each trigger advances the opcode, latches the operand-select switches, waits for the combinational ALU to settle, then captures the result and flags. Sits between the board switches/button and the ALU and display: it drives ALU opcode and operand select, and feeds a registered 16-bit half of the captured result to the digitron display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button level changes (10 ms at 50 MHz)
AUTO_PERIOD, 50000000, clock cycles between auto-mode triggers
SETTLE_CYCLES, 2, wait cycles between driving the ALU inputs and capturing its outputs (>=1)

Ports:
ALU_SEQ_clk  input  1  system clock
ALU_SEQ_rst  input  1  asynchronous active-high reset
ALU_SEQ_step_btn  input  1  raw step push-button, asynchronous and bouncing
ALU_SEQ_auto_SW  input  1  1 = auto-step mode, 0 = manual button mode (asynchronous)
ALU_SEQ_data_SW  input  3  operand-select switches (asynchronous)
ALU_SEQ_result_SW  input  1  display half select: 0 = result[15:0], 1 = result[31:16]
ALU_SEQ_ALU_result  input  32  ALU result
ALU_SEQ_ALU_zero_flag  input  1  ALU zero flag
ALU_SEQ_ALU_overflow_flag  input  1  ALU overflow flag
ALU_SEQ_ALU_OP  output  3  opcode driven to the ALU
ALU_SEQ_ALU_data_SW  output  3  latched operand select driven to the ALU
ALU_SEQ_disp_data  output  16  selected half of the captured result, to the display
ALU_SEQ_zero_led  output  1  captured zero flag
ALU_SEQ_overflow_led  output  1  captured overflow flag
ALU_SEQ_busy  output  1  high while in SETTLE or CAPTURE

Behaviour:
- Reset (asynchronous, any state): state = IDLE; ALU_OP = 0; next_op = 0; ALU_data_SW = 0; captured result = 0; disp_data = 0; both LEDs = 0; busy = 0; debounce, auto and settle counters = 0; synchronizers = 0.
- Input conditioning: step_btn, auto_SW, data_SW[2:0] and result_SW each pass through a 2-FF synchronizer.
- Debounce: the debounced level follows the synced button only after the synced button has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter. A debounced 0->1 transition produces a 1-cycle btn_pulse.
- Auto tick: the counter runs only while synced auto_SW = 1. auto_pulse fires when the count reaches AUTO_PERIOD-1, then the counter wraps to 0. The counter is held at 0 while auto_SW = 0, so the first tick comes AUTO_PERIOD cycles after auto mode is entered.
- Trigger source: trigger = auto_SW ? auto_pulse : btn_pulse. btn_pulse is ignored in auto mode.
- FSM states: IDLE, SETTLE, CAPTURE, SHOW.
  - IDLE or SHOW, on trigger: ALU_OP <= next_op; next_op <= next_op+1 (7 wraps to 0); ALU_data_SW <= synced data_SW; settle counter cleared; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: one cycle. Register ALU_result, zero_flag and overflow_flag. Go to SHOW.
  - SHOW: hold the captured values until the next trigger.
- Triggers arriving in SETTLE or CAPTURE are dropped (not queued). busy = 1 in those states.
- Operand-select switch changes after a trigger do not affect the operation in flight; the latched ALU_data_SW is used.
- Latency: trigger cycle -> ALU inputs valid next edge -> capture SETTLE_CYCLES+1 edges later -> disp_data updates one edge after capture.
- disp_data is registered: the selected half of the captured result, re-selected every cycle from synced result_SW. A result_SW change reaches disp_data in 3 cycles (2 sync + 1 register).
- A reset during SETTLE or CAPTURE abandons the operation. No partial capture occurs.

Decomposition:
- Shared package/header holds the state encoding localparams (IDLE=0, SETTLE=1, CAPTURE=2, SHOW=3) and OP_W=3, SEL_W=3, RES_W=32, DISP_W=16.
- One sub-module: alu_step_debounce (2-FF sync + stable counter + rising-edge pulse, DEBOUNCE_CYCLES parameter). It is reusable for other board buttons.
- The auto tick, FSM and display mux stay in the top module.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, AUTO_PERIOD=16, SETTLE_CYCLES=2; the ALU model returns result={29'b0, op} ^ {29'b0, sel}, with zero when result==0.
1. Reset mid-SETTLE: assert rst asynchronously -> all outputs 0 immediately, state IDLE, next trigger executes op 0.
2. Bounce rejection: step_btn toggles every 2 cycles for 20 cycles, then stays high -> exactly one trigger; ALU_OP=0; busy high for 3 cycles; zero_led=1 when data_SW=0.
3. Opcode wrap: 9 clean presses with data_SW=3'b101 -> ALU_OP sequence 0..7,0; captured result after press 6 (op 5) = 0 with zero_led=1; next_op after press 9 = 1.
4. Dropped trigger: in auto mode with SETTLE_CYCLES=20, an auto tick arriving during SETTLE -> ignored; ALU_OP advances once.
5. Auto mode: auto_SW=1, button held pressed -> ALU_OP advances once every 16 cycles, button pulses ignored; auto_SW=0 -> advancing stops and the counter resets.
6. Display select: captured result 32'hABCD_1234; result_SW 0 -> disp_data 16'h1234; result_SW 1 -> disp_data 16'hABCD within 3 cycles.

Source files
------------

// File: rtl/alu_step_sequencer_pkg.sv
// Shared types and constants for the ALU step sequencer and its button conditioning.
package alu_step_sequencer_pkg;

    localparam int OP_W   = 3;
    localparam int SEL_W  = 3;
    localparam int RES_W  = 32;
    localparam int DISP_W = 16;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_SETTLE  = 2'd1;
    localparam logic [1:0] STATE_CAPTURE = 2'd2;
    localparam logic [1:0] STATE_SHOW    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = STATE_IDLE,
        SETTLE  = STATE_SETTLE,
        CAPTURE = STATE_CAPTURE,
        SHOW    = STATE_SHOW
    } seq_state_t;

    // Opcode sequence simply counts up and wraps naturally at the field width.
    function automatic logic [OP_W-1:0] next_opcode(input logic [OP_W-1:0] op);
        return op + OP_W'(1);
    endfunction

endpackage

// File: rtl/alu_step_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle pulse
// on each debounced press.
module alu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pulse_r;
    logic             synced_s;

    assign synced_s = sync_r[1];
    assign pulse    = pulse_r;

    // Synchronize, then let the level follow only after a full run of disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r  <= 2'b00;
            cnt_r   <= '0;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], raw};
            pulse_r <= 1'b0;
            if (synced_s != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= synced_s;
                    cnt_r   <= '0;
                    pulse_r <= synced_s;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Sequences one ALU operation per button press or auto tick, then captures and
// displays the settled result and flags.
module alu_step_sequencer
    import alu_step_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic              ALU_SEQ_clk,
    input  logic              ALU_SEQ_rst,
    input  logic              ALU_SEQ_step_btn,
    input  logic              ALU_SEQ_auto_SW,
    input  logic [SEL_W-1:0]  ALU_SEQ_data_SW,
    input  logic              ALU_SEQ_result_SW,
    input  logic [RES_W-1:0]  ALU_SEQ_ALU_result,
    input  logic              ALU_SEQ_ALU_zero_flag,
    input  logic              ALU_SEQ_ALU_overflow_flag,
    output logic [OP_W-1:0]   ALU_SEQ_ALU_OP,
    output logic [SEL_W-1:0]  ALU_SEQ_ALU_data_SW,
    output logic [DISP_W-1:0] ALU_SEQ_disp_data,
    output logic              ALU_SEQ_zero_led,
    output logic              ALU_SEQ_overflow_led,
    output logic              ALU_SEQ_busy
);

    localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    logic [1:0]        auto_sync_r;
    logic [1:0]        result_sync_r;
    logic [SEL_W-1:0]  data_meta_r;
    logic [SEL_W-1:0]  data_sync_r;
    logic [AUTO_W-1:0] auto_cnt_r;
    logic [SET_W-1:0]  settle_cnt_r;
    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [OP_W-1:0]   alu_op_r;
    logic [OP_W-1:0]   next_op_r;
    logic [SEL_W-1:0]  alu_sel_r;
    logic [RES_W-1:0]  result_r;
    logic              zero_r;
    logic              ovf_r;
    logic [DISP_W-1:0] disp_r;
    logic              busy_r;
    logic              btn_pulse_s;
    logic              auto_pulse_s;
    logic              trigger_s;
    logic              load_s;
    logic              capture_s;

    alu_step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (ALU_SEQ_clk),
        .rst  (ALU_SEQ_rst),
        .raw  (ALU_SEQ_step_btn),
        .pulse(btn_pulse_s)
    );

    // Synchronize the mode, operand and display-select switches.
    always_ff @(posedge ALU_SEQ_clk or posedge ALU_SEQ_rst) begin
        if (ALU_SEQ_rst) begin
            auto_sync_r   <= 2'b00;
            result_sync_r <= 2'b00;
            data_meta_r   <= '0;
            data_sync_r   <= '0;
        end else begin
            auto_sync_r   <= {auto_sync_r[0], ALU_SEQ_auto_SW};
            result_sync_r <= {result_sync_r[0], ALU_SEQ_result_SW};
            data_meta_r   <= ALU_SEQ_data_SW;
            data_sync_r   <= data_meta_r;
        end
    end

    // Auto tick counter; held at zero outside auto mode so the first tick is a full period away.
    always_ff @(posedge ALU_SEQ_clk or posedge ALU_SEQ_rst) begin
        if (ALU_SEQ_rst) begin
            auto_cnt_r <= '0;
        end else if (!auto_sync_r[1] || (auto_cnt_r == AUTO_LAST)) begin
            auto_cnt_r <= '0;
        end else begin
            auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
        end
    end

    // Trigger selection and next-state decode.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        auto_pulse_s = auto_sync_r[1] && (auto_cnt_r == AUTO_LAST);
        if (auto_sync_r[1]) begin
            trigger_s = auto_pulse_s;
        end else begin
            trigger_s = btn_pulse_s;
        end
        case (state_r)
            IDLE, SHOW: begin
                if (trigger_s) begin
                    state_nxt_s = SETTLE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SET_LAST) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            CAPTURE: begin
                state_nxt_s = SHOW;
                capture_s   = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, operation launch, result capture and display registers.
    always_ff @(posedge ALU_SEQ_clk or posedge ALU_SEQ_rst) begin
        if (ALU_SEQ_rst) begin
            state_r      <= IDLE;
            settle_cnt_r <= '0;
            alu_op_r     <= '0;
            next_op_r    <= '0;
            alu_sel_r    <= '0;
            result_r     <= '0;
            zero_r       <= 1'b0;
            ovf_r        <= 1'b0;
            disp_r       <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SETTLE) || (state_nxt_s == CAPTURE);
            if (load_s) begin
                settle_cnt_r <= '0;
                alu_op_r     <= next_op_r;
                next_op_r    <= next_opcode(next_op_r);
                alu_sel_r    <= data_sync_r;
            end else if (state_r == SETTLE) begin
                settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
            if (capture_s) begin
                result_r <= ALU_SEQ_ALU_result;
                zero_r   <= ALU_SEQ_ALU_zero_flag;
                ovf_r    <= ALU_SEQ_ALU_overflow_flag;
            end
            if (result_sync_r[1]) begin
                disp_r <= result_r[RES_W-1 -: DISP_W];
            end else begin
                disp_r <= result_r[DISP_W-1:0];
            end
        end
    end

    assign ALU_SEQ_ALU_OP       = alu_op_r;
    assign ALU_SEQ_ALU_data_SW  = alu_sel_r;
    assign ALU_SEQ_disp_data    = disp_r;
    assign ALU_SEQ_zero_led     = zero_r;
    assign ALU_SEQ_overflow_led = ovf_r;
    assign ALU_SEQ_busy         = busy_r;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer with a small XOR ALU model; a second
// instance with a long settle time exercises dropped auto ticks.
module tb_alu_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        btn_b;
    logic        auto_a;
    logic        auto_b;
    logic [2:0]  data_sw;
    logic        result_sw;
    logic        force_en;
    logic [31:0] force_val;

    logic [2:0]  op_a, sel_a, op_b, sel_b;
    logic [15:0] disp_a, disp_b;
    logic        zero_a, ovf_a, busy_a, zero_b, ovf_b, busy_b;
    logic [31:0] res_a, res_b;

    int n_vec = 0;
    int n_err = 0;
    int trig_a = 0;
    int trig_b = 0;
    int busy_cyc_a = 0;
    logic busy_a_q = 1'b0;
    logic busy_b_q = 1'b0;

    always #5 clk = ~clk;

    // ALU model: operand XOR opcode, zero when result is 0, overflow flagged for op 7.
    assign res_a = force_en ? force_val : {29'b0, op_a ^ sel_a};
    assign res_b = {29'b0, op_b ^ sel_b};

    alu_step_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16), .SETTLE_CYCLES(2)) dut_a (
        .ALU_SEQ_clk(clk), .ALU_SEQ_rst(rst), .ALU_SEQ_step_btn(step_btn),
        .ALU_SEQ_auto_SW(auto_a), .ALU_SEQ_data_SW(data_sw), .ALU_SEQ_result_SW(result_sw),
        .ALU_SEQ_ALU_result(res_a), .ALU_SEQ_ALU_zero_flag(res_a == 32'd0),
        .ALU_SEQ_ALU_overflow_flag(op_a == 3'd7),
        .ALU_SEQ_ALU_OP(op_a), .ALU_SEQ_ALU_data_SW(sel_a), .ALU_SEQ_disp_data(disp_a),
        .ALU_SEQ_zero_led(zero_a), .ALU_SEQ_overflow_led(ovf_a), .ALU_SEQ_busy(busy_a)
    );

    alu_step_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16), .SETTLE_CYCLES(20)) dut_b (
        .ALU_SEQ_clk(clk), .ALU_SEQ_rst(rst), .ALU_SEQ_step_btn(btn_b),
        .ALU_SEQ_auto_SW(auto_b), .ALU_SEQ_data_SW(data_sw), .ALU_SEQ_result_SW(result_sw),
        .ALU_SEQ_ALU_result(res_b), .ALU_SEQ_ALU_zero_flag(res_b == 32'd0),
        .ALU_SEQ_ALU_overflow_flag(op_b == 3'd7),
        .ALU_SEQ_ALU_OP(op_b), .ALU_SEQ_ALU_data_SW(sel_b), .ALU_SEQ_disp_data(disp_b),
        .ALU_SEQ_zero_led(zero_b), .ALU_SEQ_overflow_led(ovf_b), .ALU_SEQ_busy(busy_b)
    );

    // Count operations (busy rising edges) shortly after each active edge.
    always begin
        @(posedge clk);
        #2;
        if (busy_a && !busy_a_q) trig_a++;
        if (busy_b && !busy_b_q) trig_b++;
        if (busy_a) busy_cyc_a++;
        busy_a_q = busy_a;
        busy_b_q = busy_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clean press; optionally flips the operand switches while the operation is in flight.
    task automatic press(input logic flip_sel);
        int t;
        step_btn = 1'b1;
        t = 0;
        while (!busy_a && t < 40) begin @(negedge clk); t++; end
        check("press_start", {31'b0, t < 40}, 32'd1);
        if (flip_sel) data_sw = ~data_sw;
        t = 0;
        while (busy_a && t < 40) begin @(negedge clk); t++; end
        @(negedge clk);
        step_btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int t0, c0, t;
        logic [2:0] e;
        rst = 1'b1; step_btn = 1'b0; btn_b = 1'b0; auto_a = 1'b0; auto_b = 1'b0;
        data_sw = 3'd0; result_sw = 1'b0; force_en = 1'b0; force_val = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_op", {29'b0, op_a}, 32'd0);
        check("rst_sel", {29'b0, sel_a}, 32'd0);
        check("rst_disp", {16'b0, disp_a}, 32'd0);
        check("rst_leds", {30'b0, zero_a, ovf_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bouncing button: toggles every 2 cycles, then settles high.
        t0 = trig_a; c0 = busy_cyc_a;
        for (int i = 0; i < 10; i++) begin
            step_btn = ~step_btn;
            repeat (2) @(negedge clk);
        end
        step_btn = 1'b1;
        repeat (30) @(negedge clk);
        check("bounce_trig", trig_a - t0, 32'd1);
        check("bounce_op", {29'b0, op_a}, 32'd0);
        check("bounce_busy", busy_cyc_a - c0, 32'd3);
        check("bounce_zero", {31'b0, zero_a}, 32'd1);
        step_btn = 1'b0;
        repeat (8) @(negedge clk);

        // Asynchronous reset while the operation (op 1) is settling.
        step_btn = 1'b1;
        t = 0;
        while (!busy_a && t < 40) begin @(negedge clk); t++; end
        check("midrst_start", {31'b0, t < 40}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_op", {29'b0, op_a}, 32'd0);
        check("midrst_busy", {31'b0, busy_a}, 32'd0);
        check("midrst_zero", {31'b0, zero_a}, 32'd0);
        step_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b0);
        check("midrst_next_op", {29'b0, op_a}, 32'd0);
        check("midrst_next_zero", {31'b0, zero_a}, 32'd1);

        // Opcode wrap from a fresh reset with operand select 5.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        data_sw = 3'b101;
        for (int p = 0; p < 9; p++) begin
            press(1'b0);
            e = 3'(p % 8);
            check($sformatf("wrap_op%0d", p), {29'b0, op_a}, {29'b0, e});
            check($sformatf("wrap_disp%0d", p), {16'b0, disp_a}, {29'b0, e ^ 3'b101});
            check($sformatf("wrap_zero%0d", p), {31'b0, zero_a}, {31'b0, e == 3'd5});
            check($sformatf("wrap_ovf%0d", p), {31'b0, ovf_a}, {31'b0, e == 3'd7});
        end
        press(1'b1);
        check("latch_op", {29'b0, op_a}, 32'd1);
        check("latch_sel", {29'b0, sel_a}, 32'd5);
        check("latch_disp", {16'b0, disp_a}, 32'd4);

        // Display half select (op 2 with forced ALU result).
        force_val = 32'hABCD_1234; force_en = 1'b1; result_sw = 1'b0;
        press(1'b0);
        check("disp_lo", {16'b0, disp_a}, 32'h1234);
        check("disp_zero", {31'b0, zero_a}, 32'd0);
        result_sw = 1'b1;
        repeat (2) @(negedge clk);
        check("disp_lag", {16'b0, disp_a}, 32'h1234);
        @(negedge clk);
        check("disp_hi", {16'b0, disp_a}, 32'hABCD);
        result_sw = 1'b0; force_en = 1'b0;
        repeat (4) @(negedge clk);

        // Auto mode with button held: ticks land 18, 34, 50 edges after the switch.
        t0 = trig_a; auto_a = 1'b1; step_btn = 1'b1;
        repeat (55) @(negedge clk);
        check("auto_trig", trig_a - t0, 32'd3);
        check("auto_op", {29'b0, op_a}, 32'd5);
        t0 = trig_a; auto_a = 1'b0; step_btn = 1'b0;
        repeat (40) @(negedge clk);
        check("auto_off_trig", trig_a - t0, 32'd0);
        check("auto_off_op", {29'b0, op_a}, 32'd5);
        t0 = trig_a; auto_a = 1'b1;
        repeat (16) @(negedge clk);
        check("auto_reentry_early", trig_a - t0, 32'd0);
        repeat (6) @(negedge clk);
        check("auto_reentry_tick", trig_a - t0, 32'd1);
        check("auto_reentry_op", {29'b0, op_a}, 32'd6);
        auto_a = 1'b0;
        repeat (4) @(negedge clk);

        // Long settle: the second tick arrives mid-SETTLE and is dropped.
        t0 = trig_b; auto_b = 1'b1;
        repeat (45) @(negedge clk);
        check("drop_trig", trig_b - t0, 32'd1);
        check("drop_op", {29'b0, op_b}, 32'd0);
        check("drop_sel", {29'b0, sel_b}, 32'd2);
        check("drop_disp", {16'b0, disp_b}, 32'd2);
        repeat (10) @(negedge clk);
        check("drop_next_trig", trig_b - t0, 32'd2);
        check("drop_next_op", {29'b0, op_b}, 32'd1);
        auto_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
